// File: rtl/sar_pkg.sv
// Shared constants and capture FSM encoding for the SAR result reader.
package sar_pkg;

  localparam int SAR_DATA_W    = 4;
  localparam int SAR_CNT_W     = 8;
  localparam int SAR_AVG_SHIFT = 2;
  localparam int SAR_AVG_N     = 4;

  typedef enum logic {
    ARMED    = 1'b0,
    WAIT_LOW = 1'b1
  } sar_state_t;

endpackage

// File: rtl/sar_result_fifo.sv
// Generic synchronous show-ahead FIFO: head entry is always visible on head.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle. clear empties the FIFO and has priority over push and pop.
module sar_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  lvl;
  logic              do_push;
  logic              do_pop;

  assign full    = (lvl == LVL_W'(DEPTH));
  assign empty   = (lvl == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = lvl;

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      lvl <= lvl + LVL_W'(1);
      else if (!do_push && do_pop) lvl <= lvl - LVL_W'(1);
    end
  end

endmodule

// File: rtl/sar_result_reader.sv
// Reader end of the SAR conversion interface. Captures one code per rising
// run of sar_done, counts conversions and buffers codes in a show-ahead FIFO
// drained over a valid/ready handshake.
// Optional build macro SAR_RESULT_AVG_EN: push the truncated mean of every
// four captures instead of each raw capture.
module sar_result_reader
  import sar_pkg::*;
#(
  parameter int DATA_W     = SAR_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = SAR_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             sar_bits,
  input  logic                          sar_done,
  input  logic                          clear,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [CNT_W-1:0]              conv_count
);

  sar_state_t        state;
  logic              capture;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              full;
  logic              empty;

  // A capture happens on the first edge that sees sar_done high while armed
  assign capture = (state == ARMED) && sar_done;

  // Capture FSM: one capture per high run of sar_done; clear does not rearm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARMED;
    end else begin
      case (state)
        ARMED:    if (sar_done)  state <= WAIT_LOW;
        WAIT_LOW: if (!sar_done) state <= ARMED;
        default:  state <= ARMED;
      endcase
    end
  end

  // Raw conversion counter, wrapping; a capture coinciding with clear is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       conv_count <= '0;
    else if (clear)   conv_count <= '0;
    else if (capture) conv_count <= conv_count + CNT_W'(1);
  end

`ifdef SAR_RESULT_AVG_EN
  logic [DATA_W+1:0] acc;
  logic [1:0]        smp_cnt;
  logic              last_smp;

  // Mean of the accumulated samples plus the current code, truncated
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [DATA_W+1:0] a,
                                                  input logic [DATA_W-1:0] c);
    logic [DATA_W+1:0] sum;
    sum = a + {2'b00, c};
    return sum[SAR_AVG_SHIFT +: DATA_W];
  endfunction

  assign last_smp  = (smp_cnt == 2'(SAR_AVG_N - 1));
  assign push      = capture && last_smp;
  assign push_data = avg_trunc(acc, sar_bits);

  // Accumulate three samples; the fourth completes the average and restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (capture) begin
      if (last_smp) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else begin
        acc     <= acc + {2'b00, sar_bits};
        smp_cnt <= smp_cnt + 2'd1;
      end
    end
  end
`else
  assign push      = capture;
  assign push_data = sar_bits;
`endif

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  // Sticky overflow: a push was dropped because the FIFO was full with no pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        overflow <= 1'b0;
    else if (clear)                    overflow <= 1'b0;
    else if (push && full && !pop)     overflow <= 1'b1;
  end

  sar_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  ($clog2(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (clear),
    .head      (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule
